// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
//   Multiplexed common-anode 7-segment driver. Packed BCD digits are
//   snapshotted once per full scan (on entry to digit 0's SHOW phase) so a
//   counter rollover upstream never tears the displayed value. Each digit
//   slot of REFRESH_DIV cycles starts with BLANK_CYCLES of dead time (all
//   anodes off) followed by the SHOW phase for that digit.
//
// Ports
//   clk        in   system clock
//   reset_n    in   asynchronous reset, active low
//   bcd_in     in   packed BCD, digit i = bcd_in[4i+3:4i], digit 0 rightmost
//   dp_in      in   decimal point request per digit, active high
//   blank_lz   in   1 = blank leading zeros (digit 0 never blanked)
//   enable     in   0 = all anodes off, scanning continues
//   seg_n      out  {dp,g,f,e,d,c,b,a}, active low, registered
//   an_n       out  digit anodes, active low, registered
//   scan_done  out  pulse on the last SHOW cycle of digit NUM_DIGITS-1
// ---------------------------------------------------------------------------
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  input  logic                    enable,
  output logic [7:0]              seg_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    scan_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] S_GAP  = 1'b0;
  localparam logic [0:0] S_SHOW = 1'b1;

  localparam logic [CW-1:0] L_GAP_LAST  = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] L_SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] L_IDX_LAST  = IW'(NUM_DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] f_decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h40;
    endcase
    return p;
  endfunction

  logic [0:0]              r_state;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_bcd;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [7:0]              r_seg_n;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic                    r_scan_done;

  logic [0:0]              w_state_nxt;
  logic [CW-1:0]           w_cnt_nxt;
  logic [IW-1:0]           w_idx_nxt;
  logic [4*NUM_DIGITS-1:0] w_bcd_nxt;
  logic [NUM_DIGITS-1:0]   w_dp_nxt;
  logic [3:0]              w_nib;
  logic                    w_dp_bit;
  logic                    w_lz_run;
  logic                    w_blank;
  logic [NUM_DIGITS-1:0]   w_an_sel;
  logic [7:0]              w_seg_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic                    w_done_nxt;

  // Slot sequencing: one counter spans the whole slot, GAP is its first BLANK_CYCLES counts.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_bcd_nxt   = r_shadow_bcd;
    w_dp_nxt    = r_shadow_dp;
    if (r_state == S_GAP) begin
      if (r_cnt == L_GAP_LAST) begin
        w_state_nxt = S_SHOW;
        if (r_idx == L_IDX_LAST) begin
          // Wrapping to digit 0 starts a new scan: take a coherent snapshot.
          w_idx_nxt = {IW{1'b0}};
          w_bcd_nxt = bcd_in;
          w_dp_nxt  = dp_in;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
      end else begin
        w_state_nxt = S_GAP;
      end
    end else begin
      if (r_cnt == L_SLOT_LAST) begin
        w_state_nxt = S_GAP;
        w_cnt_nxt   = {CW{1'b0}};
      end else begin
        w_state_nxt = S_SHOW;
      end
    end
  end

  // Digit select and leading-zero detection, evaluated on the next-state shadow
  // so the edge that takes the snapshot already displays the new frame.
  always_comb begin
    w_nib    = 4'h0;
    w_dp_bit = 1'b0;
    w_lz_run = 1'b1;
    w_blank  = 1'b0;
    w_an_sel = {NUM_DIGITS{1'b1}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      // w_lz_run = every digit from the most significant down to i is zero
      w_lz_run    = w_lz_run & (w_bcd_nxt[4*i +: 4] == 4'h0);
      w_nib       = (w_idx_nxt == IW'(i)) ? w_bcd_nxt[4*i +: 4] : w_nib;
      w_dp_bit    = (w_idx_nxt == IW'(i)) ? w_dp_nxt[i] : w_dp_bit;
      w_blank     = (w_idx_nxt == IW'(i)) ? (blank_lz & w_lz_run & (i != 0)) : w_blank;
      w_an_sel[i] = (w_idx_nxt == IW'(i)) ? 1'b0 : 1'b1;
    end
  end

  // Output values for the next cycle; GAP forces everything dark.
  always_comb begin
    w_seg_nxt  = 8'hFF;
    w_an_nxt   = {NUM_DIGITS{1'b1}};
    w_done_nxt = 1'b0;
    if (w_state_nxt == S_SHOW) begin
      w_seg_nxt  = ~{w_dp_bit, (w_blank ? 7'h00 : f_decode(w_nib))};
      w_an_nxt   = enable ? w_an_sel : {NUM_DIGITS{1'b1}};
      w_done_nxt = (w_idx_nxt == L_IDX_LAST) && (w_cnt_nxt == L_SLOT_LAST);
    end else begin
      w_seg_nxt  = 8'hFF;
      w_an_nxt   = {NUM_DIGITS{1'b1}};
      w_done_nxt = 1'b0;
    end
  end

  // State, snapshot and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_GAP;
      r_cnt        <= {CW{1'b0}};
      r_idx        <= L_IDX_LAST;
      r_shadow_bcd <= {(4*NUM_DIGITS){1'b0}};
      r_shadow_dp  <= {NUM_DIGITS{1'b0}};
      r_seg_n      <= 8'hFF;
      r_an_n       <= {NUM_DIGITS{1'b1}};
      r_scan_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_idx        <= w_idx_nxt;
      r_shadow_bcd <= w_bcd_nxt;
      r_shadow_dp  <= w_dp_nxt;
      r_seg_n      <= w_seg_nxt;
      r_an_n       <= w_an_nxt;
      r_scan_done  <= w_done_nxt;
    end
  end

  assign seg_n     = r_seg_n;
  assign an_n      = r_an_n;
  assign scan_done = r_scan_done;

endmodule

// File: tb/tb_seven_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan
//   Directed and randomized stimulus for seven_seg_scan (4 digits, 8-cycle
//   slot, 2 blank cycles). Expected outputs come from a timeline model: the
//   number of clock edges since reset release gives slot, position in slot,
//   digit and scan; the frame is latched whenever digit 0's SHOW begins.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

  localparam int N  = 4;
  localparam int RD = 8;
  localparam int BG = 2;

  logic          clk;
  logic          reset_n;
  logic [15:0]   bcd_in;
  logic [3:0]    dp_in;
  logic          blank_lz;
  logic          enable;
  logic [7:0]    seg_n;
  logic [3:0]    an_n;
  logic          scan_done;

  int            t;
  int            n_cmp;
  int            n_fail;
  logic [15:0]   sh_bcd;
  logic [3:0]    sh_dp;
  logic [6:0]    seg_tbl [10];

  seven_seg_scan #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BG)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .blank_lz  (blank_lz),
    .enable    (enable),
    .seg_n     (seg_n),
    .an_n      (an_n),
    .scan_done (scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input logic [3:0] v);
    if (v > 4'd9) return 7'h40;
    else return seg_tbl[v];
  endfunction

  // One clock edge; inputs are held constant across it, then outputs are
  // compared 1 time unit later against the timeline model.
  task automatic step();
    int          slot;
    int          pos;
    int          d;
    logic        show;
    logic        en_e;
    logic        lz_e;
    logic [15:0] bcd_e;
    logic [3:0]  dp_e;
    logic        allz;
    logic        blank;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic        exp_done;
    en_e  = enable;
    lz_e  = blank_lz;
    bcd_e = bcd_in;
    dp_e  = dp_in;
    @(posedge clk);
    #1;
    t++;
    slot = t / RD;
    pos  = t % RD;
    d    = slot % N;
    show = (pos >= BG);
    if (pos == BG && d == 0) begin
      sh_bcd = bcd_e;
      sh_dp  = dp_e;
    end
    exp_seg  = 8'hFF;
    exp_an   = 4'hF;
    exp_done = 1'b0;
    if (show) begin
      allz = 1'b1;
      for (int k = d; k < N; k++) begin
        if (sh_bcd[4*k +: 4] != 4'h0) allz = 1'b0;
      end
      blank    = lz_e && (d > 0) && allz;
      exp_seg  = ~{sh_dp[d], (blank ? 7'h00 : pat(sh_bcd[4*d +: 4]))};
      exp_an   = en_e ? ~(4'b0001 << d) : 4'hF;
      exp_done = (pos == RD - 1) && (d == N - 1);
    end
    n_cmp++;
    assert (seg_n === exp_seg) else begin
      n_fail++;
      $error("FAIL seg_n t=%0d observed=%h expected=%h", t, seg_n, exp_seg);
    end
    n_cmp++;
    assert (an_n === exp_an) else begin
      n_fail++;
      $error("FAIL an_n t=%0d observed=%b expected=%b", t, an_n, exp_an);
    end
    n_cmp++;
    assert (scan_done === exp_done) else begin
      n_fail++;
      $error("FAIL scan_done t=%0d observed=%b expected=%b", t, scan_done, exp_done);
    end
  endtask

  // Assert reset away from a clock edge, confirm outputs go dark at once,
  // hold for two edges, then release with the model restarted.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    assert (seg_n === 8'hFF && an_n === 4'hF && scan_done === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset observed=%h/%b/%b expected=ff/1111/0", seg_n, an_n, scan_done);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    t      = 0;
    sh_bcd = 16'h0000;
    sh_dp  = 4'h0;
  endtask

  initial begin
    seg_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    n_cmp    = 0;
    n_fail   = 0;
    t        = 0;
    sh_bcd   = 16'h0000;
    sh_dp    = 4'h0;
    reset_n  = 1'b0;
    bcd_in   = 16'h0000;
    dp_in    = 4'h0;
    blank_lz = 1'b0;
    enable   = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    assert (seg_n === 8'hFF && an_n === 4'hF && scan_done === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_state observed=%h/%b/%b expected=ff/1111/0", seg_n, an_n, scan_done);
    end
    reset_n = 1'b1;
    t       = 0;

    // Test 1: basic scan of 1259
    bcd_in = 16'h1259;
    repeat (32) begin
      step();
      if (t == 2) begin
        n_cmp++;
        assert (seg_n === 8'h90 && an_n === 4'b1110) else begin
          n_fail++;
          $error("FAIL first_show observed=%h/%b expected=90/1110", seg_n, an_n);
        end
      end
      if (t == 26) begin
        n_cmp++;
        assert (seg_n === 8'hF9 && an_n === 4'b0111) else begin
          n_fail++;
          $error("FAIL digit3_show observed=%h/%b expected=f9/0111", seg_n, an_n);
        end
      end
    end

    // Test 2: input changes mid-scan do not tear the displayed frame
    bcd_in = 16'h0059;
    while (t < 52) step();
    bcd_in = 16'h0100;
    while (t < 100) step();

    // Test 3: leading-zero blanking, then an all-zero value
    blank_lz = 1'b1;
    bcd_in   = 16'h0005;
    while (t < 132) step();
    bcd_in = 16'h0000;
    while (t < 164) step();

    // Test 4: dash for non-decimal nibble and decimal point
    blank_lz = 1'b0;
    bcd_in   = 16'h00A0;
    dp_in    = 4'b0100;
    while (t < 200) step();

    // Test 5: enable low for 20 cycles mid-scan
    dp_in  = 4'h0;
    bcd_in = 16'h1234;
    while (t < 213) step();
    enable = 1'b0;
    repeat (20) step();
    enable = 1'b1;
    while (t < 280) step();

    // Test 6: reset during digit 2 SHOW, then the first sequence repeats
    while ((t % 32) != 20) step();
    do_reset();
    bcd_in = 16'h1259;
    repeat (40) step();

    // Randomized phase
    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) bcd_in = 16'($urandom);
      if ($urandom_range(0, 19) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      if ($urandom_range(0, 39) == 0) bcd_in = {4'h0, 4'h0, 4'($urandom), 4'($urandom)};
      step();
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
